// File: rtl/imm_gen_pipe_if.sv
// Handshake bundle for imm_gen_pipe: instruction in, decoded immediate/target out.
// The block attaches through the slave modport; the producer/consumer side uses master.
interface imm_gen_pipe_if #(
  parameter int unsigned DataWidth = 32,
  parameter int unsigned TagWidth  = 4
);
  logic                 flush;
  logic                 in_valid;
  logic                 in_ready;
  logic [DataWidth-1:0] in_pc;
  logic [31:0]          in_instr;
  logic [TagWidth-1:0]  in_tag;
  logic                 out_valid;
  logic                 out_ready;
  logic [2:0]           out_type;
  logic [DataWidth-1:0] out_imm;
  logic [DataWidth-1:0] out_target;
  logic [TagWidth-1:0]  out_tag;
  logic                 out_misalign;

  modport master (
    output flush, in_valid, in_pc, in_instr, in_tag, out_ready,
    input  in_ready, out_valid, out_type, out_imm, out_target, out_tag, out_misalign
  );

  modport slave (
    input  flush, in_valid, in_pc, in_instr, in_tag, out_ready,
    output in_ready, out_valid, out_type, out_imm, out_target, out_tag, out_misalign
  );
endinterface

// File: rtl/imm_gen_pipe.sv
// Opcode-aware RV32 immediate/target generator feeding a 2-entry output buffer.
// Optional feature macro: IMM_MISALIGN_CHECK_EN (stores a B/J target misalignment flag).
module imm_gen_pipe #(
  parameter int unsigned DataWidth = 32,
  parameter int unsigned TagWidth  = 4
) (
  input  logic          clk,
  input  logic          reset,
  imm_gen_pipe_if.slave bus
);

  localparam int unsigned CountW = 2;

  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpOpImm  = 7'b0010011;
  localparam logic [6:0] OpSystem = 7'b1110011;

  typedef enum logic [2:0] {
    FmtNone = 3'd0,
    FmtI    = 3'd1,
    FmtS    = 3'd2,
    FmtB    = 3'd3,
    FmtU    = 3'd4,
    FmtJ    = 3'd5
  } fmt_e;

  typedef struct packed {
    logic [2:0]           fmt;
    logic [DataWidth-1:0] imm;
    logic [DataWidth-1:0] target;
    logic [TagWidth-1:0]  tag;
`ifdef IMM_MISALIGN_CHECK_EN
    logic                 misalign;
`endif
  } entry_t;

  logic [6:0]           w_opcode;
  fmt_e                 w_fmt;
  logic [31:0]          w_imm32;
  logic [DataWidth-1:0] w_imm;
  logic                 w_pc_rel;
  logic [DataWidth-1:0] w_target;
  entry_t               w_new;
  logic                 w_in_ready;
  logic                 w_push;
  logic                 w_pop;

  logic [CountW-1:0]    r_count;
  entry_t               r_head;
  entry_t               r_tail;

  assign w_opcode = bus.in_instr[6:0];

  // Opcode to immediate format
  always_comb begin
    w_fmt = FmtNone;
    case (w_opcode)
      OpLui, OpAuipc:                    w_fmt = FmtU;
      OpJal:                             w_fmt = FmtJ;
      OpBranch:                          w_fmt = FmtB;
      OpStore:                           w_fmt = FmtS;
      OpJalr, OpLoad, OpOpImm, OpSystem: w_fmt = FmtI;
      default:                           w_fmt = FmtNone;
    endcase
  end

  // Field extraction, already sign-extended to 32 bits
  always_comb begin
    w_imm32 = '0;
    case (w_fmt)
      FmtI: w_imm32 = {{20{bus.in_instr[31]}}, bus.in_instr[31:20]};
      FmtS: w_imm32 = {{20{bus.in_instr[31]}}, bus.in_instr[31:25], bus.in_instr[11:7]};
      FmtB: w_imm32 = {{19{bus.in_instr[31]}}, bus.in_instr[31], bus.in_instr[7],
                       bus.in_instr[30:25], bus.in_instr[11:8], 1'b0};
      FmtU: w_imm32 = {bus.in_instr[31:12], 12'b0};
      FmtJ: w_imm32 = {{11{bus.in_instr[31]}}, bus.in_instr[31], bus.in_instr[19:12],
                       bus.in_instr[20], bus.in_instr[30:21], 1'b0};
      default: w_imm32 = '0;
    endcase
  end

  // Signed cast widens by replicating bit 31 up to the datapath width
  assign w_imm = DataWidth'($signed(w_imm32));

  // JALR is excluded: rs1 is not visible to this stage
  assign w_pc_rel = (w_fmt == FmtB) || (w_fmt == FmtJ) || (w_opcode == OpAuipc);
  assign w_target = w_pc_rel ? (bus.in_pc + w_imm) : '0;

  always_comb begin
    w_new        = '0;
    w_new.fmt    = w_fmt;
    w_new.imm    = w_imm;
    w_new.target = w_target;
    w_new.tag    = bus.in_tag;
`ifdef IMM_MISALIGN_CHECK_EN
    w_new.misalign = ((w_fmt == FmtB) || (w_fmt == FmtJ)) && w_target[1];
`endif
  end

  assign w_in_ready = (r_count != CountW'(2));
  assign w_push     = bus.in_valid && w_in_ready && !bus.flush;
  assign w_pop      = (r_count != CountW'(0)) && bus.out_ready;

  // Head/tail buffer; the head register drives the outputs directly
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
      r_head  <= '0;
      r_tail  <= '0;
    end else if (bus.flush) begin
      r_count <= '0;
    end else begin
      case (r_count)
        CountW'(0): begin
          if (w_push) begin
            r_head  <= w_new;
            r_count <= CountW'(1);
          end
        end
        CountW'(1): begin
          if (w_push && w_pop) begin
            r_head <= w_new;
          end else if (w_push) begin
            r_tail  <= w_new;
            r_count <= CountW'(2);
          end else if (w_pop) begin
            r_count <= CountW'(0);
          end
        end
        default: begin
          if (w_pop) begin
            r_head  <= r_tail;
            r_count <= CountW'(1);
          end
        end
      endcase
    end
  end

  assign bus.in_ready   = w_in_ready;
  assign bus.out_valid  = (r_count != CountW'(0));
  assign bus.out_type   = r_head.fmt;
  assign bus.out_imm    = r_head.imm;
  assign bus.out_target = r_head.target;
  assign bus.out_tag    = r_head.tag;
`ifdef IMM_MISALIGN_CHECK_EN
  assign bus.out_misalign = r_head.misalign;
`else
  assign bus.out_misalign = 1'b0;
`endif

endmodule

// File: doc/imm_gen_pipe.md
# imm_gen_pipe

Pipelined, opcode-aware immediate and target generator for the Buraq-mini decode stage. It accepts a full 32-bit RV32 instruction plus its PC over a valid/ready handshake and decodes the opcode to pick the immediate format. It emits a sign-extended immediate, the PC-relative target and the format code through a 2-entry output buffer, so decode can stall without dropping work.

## Interface
- `DataWidth`, 32, datapath width for PC, immediate and target; must be ≥ 32.
- `TagWidth`, 4, width of the opaque sideband tag carried with each instruction.

- `clk`  in  1  core clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `flush`  in  1  drops all buffered entries and any same-cycle push.
- `in_valid`  in  1  producer has an instruction.
- `in_ready`  out  1  block can accept this cycle.
- `in_pc`  in  DataWidth  PC of the instruction.
- `in_instr`  in  32  raw instruction.
- `in_tag`  in  TagWidth  sideband tag, passed through unchanged.
- `out_valid`  out  1  head entry valid.
- `out_ready`  in  1  consumer takes the head entry.
- `out_type`  out  3  format code: 0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J.
- `out_imm`  out  DataWidth  sign-extended immediate.
- `out_target`  out  DataWidth  PC-relative target.
- `out_tag`  out  TagWidth  tag of the head entry.
- `out_misalign`  out  1  target misalignment flag (see Configuration).

## Operation
- Opcode map, using `in_instr[6:0]`:
  - 0110111 LUI → U
  - 0010111 AUIPC → U
  - 1101111 JAL → J
  - 1100011 BRANCH → B
  - 0100011 STORE → S
  - 1100111 JALR, 0000011 LOAD, 0010011 OP-IMM, 1110011 SYSTEM → I
  - any other opcode → NONE
- Immediate fields (standard RV32):
  - I = `instr[31:20]`
  - S = {`[31:25]`,`[11:7]`}
  - B = {`[31]`,`[7]`,`[30:25]`,`[11:8]`,0}
  - U = {`[31:12]`,12'b0}
  - J = {`[31]`,`[19:12]`,`[20]`,`[30:21]`,0}
- Sign-extension: every format is sign-extended from its top bit to `DataWidth`. U is extended from bit 31. NONE gives `out_imm` = 0.
- Target:
  - B, J and AUIPC: `out_target` = PC + imm, computed modulo 2^DataWidth with carry discarded.
  - All other formats, including JALR (rs1 is not available here): `out_target` = 0.
- Buffer: a 2-entry FIFO of {type, imm, target, tag, misalign}. `count` ∈ {0,1,2}.
- Push occurs when `in_valid && in_ready && !flush`. Pop occurs when `out_valid && out_ready`.
- `in_ready` = (`count` != 2). It is a registered-state function only and does not depend on `out_ready`.
- `out_valid` = (`count` != 0). `out_*` always show the head entry.
- `flush`: next `count` = 0. Flush overrides both push and pop in the same cycle.

## Timing
- Latency: an instruction accepted in cycle N is presented at the output in cycle N+1 when the buffer was empty. Decode is done combinationally before the buffer write.
- Throughput: 1 per cycle while `out_ready` is held high.
- Simultaneous push and pop:
  - `count` 1 → stays 1; the head advances to the new entry.
  - `count` 2 → no push possible (`in_ready` = 0); pop leaves `count` at 1.
- Empty with `out_ready` high: no pop, outputs unchanged.
- Output stability: while `out_valid && !out_ready`, all `out_*` are held stable.
- Reset (any cycle, including mid-stream): `count` = 0 and all storage is cleared, so `out_valid` = 0, `out_type`/`out_imm`/`out_target`/`out_tag`/`out_misalign` = 0 and `in_ready` = 1 in the following cycle. Reset has priority over `flush`, push and pop.

## Configuration
- `IMM_MISALIGN_CHECK_EN` defined:
  - For B and J entries, `out_misalign` = `target[1]`, i.e. the target is not 4-byte aligned (no RVC).
  - For all other formats, `out_misalign` = 0.
  - The flag is computed at push and stored with the entry.
- `IMM_MISALIGN_CHECK_EN` not defined: `out_misalign` is tied to 0 and no storage bit is instantiated. The port stays present.

## Test plan
- BEQ: `in_instr`=0xFE000EE3, `in_pc`=0x100, `out_ready`=1 → next cycle `out_type`=3, `out_imm`=0xFFFFFFFC, `out_target`=0x000000FC, `out_misalign`=0.
- LUI then ADDI back to back: 0x123450B7 then 0xFFF00093 →
  - first entry: type 4, imm 0x12345000, target 0
  - second entry: type 1, imm 0xFFFFFFFF
  - the entries appear on consecutive cycles.
- JAL misaligned: 0x0020006F at PC 0x100 → type 5, imm 0x2, target 0x102. `out_misalign`=1 with the macro, 0 without it.
- Backpressure: `out_ready`=0, offer three instructions on consecutive cycles →
  - `in_ready` drops after the 2nd accept; the 3rd is held
  - `out_*` stay stable on the 1st entry
  - raising `out_ready` drains the entries in order, then the 3rd is accepted.
- Flush/reset: with `count`=2, assert `flush` together with `in_valid` → next cycle `out_valid`=0, `count`=0, nothing pushed. Repeat with `reset` → all outputs 0 and `in_ready`=1.
- Unknown opcode 0x0000007F, plus `DataWidth`=64 run with BEQ as above → first case: type 0, imm 0, target 0. Second case: imm 0xFFFFFFFFFFFFFFFC, target 0xFC.
